// File: rtl/delay_pkg.sv
// Shared types and helpers for the programmable delay line.
package delay_pkg;

  localparam int DEFAULT_DW        = 20;
  localparam int DEFAULT_MAX_DEPTH = 8;

  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } dl_state_e;

  // A request of zero still means one clock of delay; anything too long saturates.
  function automatic int unsigned clamp_delay(input int unsigned sel,
                                              input int unsigned max_depth);
    if (sel == 0)
      return 1;
    else if (sel > max_depth)
      return max_depth;
    else
      return sel;
  endfunction

endpackage

// File: rtl/delay_stage.sv
// One delay-line stage: a data register plus a valid flag with its own clear.
module delay_stage #(
  parameter int DW = 20
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          clr_valid,
  input  logic          d_valid,
  input  logic [DW-1:0] d_data,
  output logic          q_valid,
  output logic [DW-1:0] q_data
);

  // Data is never cleared by a flush; only the valid flag is.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_valid <= 1'b0;
      q_data  <= '0;
    end else begin
      if (en)
        q_data <= d_data;
      if (clr_valid)
        q_valid <= 1'b0;
      else if (en)
        q_valid <= d_valid;
    end
  end

endmodule

// File: rtl/delay_line_prog.sv
// Programmable-latency delay line: tap selected per clock, refill gating after
// reset or any change of the effective delay.
module delay_line_prog
  import delay_pkg::*;
#(
  parameter int DW        = DEFAULT_DW,
  parameter int MAX_DEPTH = DEFAULT_MAX_DEPTH,
  parameter int SELW      = $clog2(MAX_DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            in_valid,
  input  logic [DW-1:0]   in_data,
  input  logic [SELW-1:0] delay_sel,
  output logic            out_valid,
  output logic [DW-1:0]   out_data,
  output logic            filling
);

  localparam int RST_DLY = (MAX_DEPTH < 3) ? MAX_DEPTH : 3;

  logic [SELW-1:0] d_eff;
  logic [SELW-1:0] dly_q;
  logic [SELW-1:0] tap_idx;
  logic [SELW-1:0] fill_cnt_q;
  logic [SELW-1:0] fill_cnt_d;
  logic            dly_change;
  dl_state_e       state_q;
  dl_state_e       state_d;

  logic            stage_v [MAX_DEPTH];
  logic [DW-1:0]   stage_d [MAX_DEPTH];
  logic            tap_v;
  logic [DW-1:0]   tap_d;

  assign d_eff      = SELW'(clamp_delay(32'(delay_sel), MAX_DEPTH));
  assign dly_change = (d_eff != dly_q);
  assign tap_idx    = dly_q - SELW'(1);

  // The delay register tracks the request even while the line is frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      dly_q <= SELW'(RST_DLY);
    else
      dly_q <= d_eff;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FILL;
      fill_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
    end
  end

  // A delay change restarts the refill and wins over finishing the current one.
  always_comb begin
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    if (dly_change) begin
      state_d    = FILL;
      fill_cnt_d = '0;
    end else if (en && (state_q == FILL)) begin
      if (fill_cnt_q == tap_idx)
        state_d = RUN;
      else
        fill_cnt_d = fill_cnt_q + SELW'(1);
    end
  end

  for (genvar k = 0; k < MAX_DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_head
      // The head stage keeps the incoming sample on a flush edge if it is enabled.
      delay_stage #(.DW(DW)) u_stage (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .clr_valid(dly_change && !en),
        .d_valid  (in_valid),
        .d_data   (in_data),
        .q_valid  (stage_v[0]),
        .q_data   (stage_d[0])
      );
    end else begin : g_body
      delay_stage #(.DW(DW)) u_stage (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .clr_valid(dly_change),
        .d_valid  (stage_v[k-1]),
        .d_data   (stage_d[k-1]),
        .q_valid  (stage_v[k]),
        .q_data   (stage_d[k])
      );
    end
  end

  always_comb begin
    tap_v = 1'b0;
    tap_d = '0;
    for (int k = 0; k < MAX_DEPTH; k++) begin
      if (tap_idx == SELW'(k)) begin
        tap_v = stage_v[k];
        tap_d = stage_d[k];
      end
    end
  end

  assign out_data  = tap_d;
  assign out_valid = tap_v && (state_q == RUN);
  assign filling   = (state_q == FILL);

endmodule

// File: tb/tb_delay_line_prog.sv
// Self-checking bench for delay_line_prog: history-based reference model,
// directed scenarios with literal expectations, then randomized traffic.
module tb_delay_line_prog;

  localparam int DW   = 20;
  localparam int MAXD = 8;
  localparam int SELW = 4;
  localparam int HIST = 8192;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            en = 1'b0;
  logic            in_valid = 1'b0;
  logic [DW-1:0]   in_data = '0;
  logic [SELW-1:0] delay_sel = 4'd3;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic            filling;

  int errors = 0;
  int checks = 0;

  delay_line_prog #(.DW(DW), .MAX_DEPTH(MAXD), .SELW(SELW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .in_valid (in_valid),
    .in_data  (in_data),
    .delay_sel(delay_sel),
    .out_valid(out_valid),
    .out_data (out_data),
    .filling  (filling)
  );

  always #5 clk = ~clk;

  // Model: list of every accepted sample since reset; the tap is the sample
  // accepted dly enabled edges ago, valid only if accepted after the last flush.
  bit            hv [HIST];
  logic [DW-1:0] hd [HIST];
  int            n = 0;
  int            floorIdx = 0;
  int            since = 0;
  int            dly = 3;

  function automatic int clampSel(input int s);
    if (s < 1) return 1;
    if (s > MAXD) return MAXD;
    return s;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n = 0;
      floorIdx = 0;
      since = 0;
      dly = 3;
    end else begin
      int dNew;
      int nBefore;
      dNew = clampSel(int'(delay_sel));
      nBefore = n;
      if (en && n < HIST) begin
        hv[n] = in_valid;
        hd[n] = in_data;
        n = n + 1;
      end
      if (dNew != dly) begin
        floorIdx = nBefore;
        since = 0;
      end else if (en && since < 100000) begin
        since = since + 1;
      end
      dly = dNew;
    end
  end

  task automatic expOut(output bit v, output logic [DW-1:0] d, output bit f);
    int idx;
    idx = n - dly;
    if (idx < 0) begin
      v = 1'b0;
      d = '0;
    end else begin
      v = hv[idx] && (idx >= floorIdx);
      d = hd[idx];
    end
    f = (since < dly);
    v = v && !f;
  endtask

  task automatic checkOutput(input string tag);
    bit            ev;
    logic [DW-1:0] ed;
    bit            ef;
    expOut(ev, ed, ef);
    checks += 3;
    if (out_valid !== ev) begin
      errors++;
      $display("[TB] FAIL %s out_valid got %0b want %0b (t=%0t)", tag, out_valid, ev, $time);
    end
    if (out_data !== ed) begin
      errors++;
      $display("[TB] FAIL %s out_data got %0h want %0h (t=%0t)", tag, out_data, ed, $time);
    end
    if (filling !== ef) begin
      errors++;
      $display("[TB] FAIL %s filling got %0b want %0b (t=%0t)", tag, filling, ef, $time);
    end
  endtask

  task automatic checkLiteral(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s got %0d want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit e, input bit v, input int d, input int sel);
    en = e;
    in_valid = v;
    in_data = DW'(d);
    delay_sel = SELW'(sel);
    @(negedge clk);
    checkOutput("model");
  endtask

  initial begin
    bit pat [4];
    int curSel;
    pat = '{1'b1, 1'b0, 1'b1, 1'b1};

    repeat (2) @(negedge clk);
    checkOutput("reset");
    checkLiteral("reset_out_valid", int'(out_valid), 0);
    checkLiteral("reset_out_data", int'(out_data), 0);
    checkLiteral("reset_filling", int'(filling), 1);
    rst_n = 1'b1;

    // First sample emerges on the third enabled edge after reset.
    applyStimulus(1, 1, 1, 3);
    checkLiteral("fill_e1_filling", int'(filling), 1);
    applyStimulus(1, 1, 2, 3);
    checkLiteral("fill_e2_out_valid", int'(out_valid), 0);
    applyStimulus(1, 1, 3, 3);
    checkLiteral("fill_e3_out_valid", int'(out_valid), 1);
    checkLiteral("fill_e3_out_data", int'(out_data), 1);
    checkLiteral("fill_e3_filling", int'(filling), 0);
    for (int i = 4; i < 8; i++) applyStimulus(1, 1, i, 3);

    for (int i = 0; i < 6; i++) applyStimulus(1, 1, 100 + i, 0);
    checkLiteral("sel0_out_data", int'(out_data), 105);
    checkLiteral("sel0_out_valid", int'(out_valid), 1);

    for (int i = 0; i < 12; i++) applyStimulus(1, 1, 200 + i, 15);
    checkLiteral("sel15_out_data", int'(out_data), 204);
    checkLiteral("sel15_out_valid", int'(out_valid), 1);

    for (int i = 0; i < 5; i++) applyStimulus(1, 1, 300 + i, 3);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 1, 400 + i, 5);
      checkLiteral("chg5_gap_out_valid", int'(out_valid), 0);
    end
    applyStimulus(1, 1, 405, 5);
    checkLiteral("chg5_first_out_valid", int'(out_valid), 1);
    checkLiteral("chg5_first_out_data", int'(out_data), 401);

    // Freeze mid-stream: output holds, then resumes without gaps.
    for (int i = 0; i < 6; i++) applyStimulus(1, 1, 500 + i, 4);
    checkLiteral("frz_pre_out_data", int'(out_data), 502);
    for (int i = 0; i < 2; i++) begin
      applyStimulus(0, 1, 20'hAAAAA, 4);
      checkLiteral("frz_hold_out_data", int'(out_data), 502);
    end
    for (int i = 6; i < 12; i++) applyStimulus(1, 1, 500 + i, 4);
    checkLiteral("frz_post_out_data", int'(out_data), 508);

    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 600 + i, 2);
    applyStimulus(1, pat[0], 610, 2);
    for (int j = 1; j < 4; j++) begin
      applyStimulus(1, pat[j], 610 + j, 2);
      checkLiteral("vpat_out_valid", int'(out_valid), int'(pat[j-1]));
    end
    applyStimulus(1, 1, 620, 2);
    checkLiteral("vpat_last_out_valid", int'(out_valid), int'(pat[3]));

    for (int i = 0; i < 10; i++) applyStimulus(1, 1, 700 + i, 6);
    checkLiteral("run6_out_valid", int'(out_valid), 1);
    #2 rst_n = 1'b0;
    delay_sel = 4'd3;
    #1;
    checkLiteral("midrst_out_valid", int'(out_valid), 0);
    checkLiteral("midrst_out_data", int'(out_data), 0);
    checkLiteral("midrst_filling", int'(filling), 1);
    checkOutput("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1, 1, 800, 3);
    applyStimulus(1, 1, 801, 3);
    checkLiteral("postrst_e2_out_data", int'(out_data), 0);
    applyStimulus(1, 1, 802, 3);
    checkLiteral("postrst_e3_out_data", int'(out_data), 800);
    checkLiteral("postrst_e3_out_valid", int'(out_valid), 1);

    curSel = 3;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 39) == 0) curSel = int'($urandom_range(0, 15));
      if ($urandom_range(0, 299) == 0) begin
        #3 rst_n = 1'b0;
        #1 checkOutput("rnd_reset");
        @(negedge clk);
        rst_n = 1'b1;
      end
      applyStimulus($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0,
                    int'($urandom_range(0, (1 << DW) - 1)), curSel);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
